multibank_serial_fir: RTL and testbench
=======================================

Name: multibank_serial_fir

Overview:
Parametrised successor to the fixed four-bank FIR in the ADC→filter→saturator→DAC chain on the sclk domain. The block provides BANKS runtime-writable coefficient banks of TAPS taps each and uses one time-multiplexed multiply-accumulate unit. It adds sink backpressure, overrun reporting and offset-binary input conversion. It sits between adc_serial and variable_saturation.

Parameters:
DATA_W, 12, input sample width
COEF_W, 16, signed coefficient width
TAPS, 16, taps per bank (≥2)
BANKS, 4, number of coefficient banks (≥1)
BANK_W, 2, bank index width (≥ clog2(BANKS), ≥1)
ACC_W, 32, accumulator/output width (default = DATA_W+COEF_W+clog2(TAPS))
INPUT_SIGNED, 0, 0 = offset-binary input (MSB inverted on entry); 1 = two's complement

Ports:
clk  in  1  sclk domain clock
reset_n  in  1  reset, asynchronous, active-low
bank_select  in  BANK_W  bank for the next accepted sample
ast_sink_data  in  DATA_W  input sample
ast_sink_valid  in  1  sample strobe
ast_sink_error  in  2  upstream error
ast_sink_ready  out  1  high when a sample can be accepted
coef_wr_en  in  1  coefficient write strobe
coef_wr_bank  in  BANK_W  write bank
coef_wr_addr  in  clog2(TAPS)  write tap index
coef_wr_data  in  COEF_W  signed coefficient
ast_source_data  out  ACC_W  signed filter result
ast_source_valid  out  1  one-cycle result strobe
ast_source_error  out  2  result error
busy  out  1  high in MAC or OUT

Behaviour:
- Reset (async, reset_n=0): state IDLE; delay line, all coefficients, accumulator, tap index and overrun flag cleared. Outputs: ast_sink_ready=1, ast_source_valid=0, ast_source_data=0, ast_source_error=0, busy=0. A reset during MAC aborts the computation and produces no output.
- FSM states: IDLE → MAC → OUT → IDLE.
- IDLE: ast_sink_ready=1. Accept when ast_sink_valid=1. On accept:
  - shift the converted sample into x[0] (x[k]←x[k-1]; oldest sample discarded);
  - latch bank_select as bank_l and ast_sink_error as err_l;
  - acc←0, idx←0; go to MAC.
- MAC: one tap per cycle: acc += x[idx]·coef[bank_l][idx], idx++. After TAPS cycles (idx=TAPS-1 consumed) go to OUT. ast_sink_ready=0.
- OUT: ast_source_data←acc, ast_source_valid=1 for exactly this cycle, ast_source_error←err_l | {ovr,1'b0}. ovr is cleared. Return to IDLE. Sink is not ready in OUT.
- Latency: accept in cycle 0 → ast_source_valid in cycle TAPS+1. Maximum throughput is one sample per TAPS+2 cycles.
- Overrun: ast_sink_valid=1 while ast_sink_ready=0 drops the sample (delay line unchanged) and sets ovr. ovr is reported on the next output, then cleared. Multiple drops yield one flag. A drop in the same cycle as OUT is reported on the following output.
- Input conversion: INPUT_SIGNED=0 → MSB inverted (0x800→0, 0xFFF→+2047, 0x000→-2048). INPUT_SIGNED=1 → data used as-is.
- Arithmetic: signed × signed full-precision product, sign-extended to ACC_W. Accumulation wraps modulo 2^ACC_W with no saturation; downstream saturator owns range.
- Upstream error: a nonzero ast_sink_error does not block processing; the sample is filtered and the error propagated.
- Coefficient writes: accepted in any state, 1-cycle write. A write to bank_l during MAC affects only taps not yet consumed: a tap whose idx equals the write address in the same cycle uses the old value. Write bank ≥ BANKS or address ≥ TAPS is ignored.
- bank_select changes mid-computation do not affect the current result; they apply at the next accept.

Test Plan:
- TAPS=4, bank0 coefs {1,2,3,4}, INPUT_SIGNED=1, impulse 0x001 then three 0x000 samples → outputs 1,2,3,4; valid 5 cycles after each accept.
- INPUT_SIGNED=0, all coefs in bank1 = 1, bank_select=1, four samples 0xFFF → outputs 2047, 4094, 6141, 8188.
- bank0={1,0,0,0}, bank2={-1,0,0,0}; bank_select toggles 0→2 during MAC of sample 0x005 → output 5. Next sample 0x005 with bank 2 → -5.
- Valid strobes every 2 cycles, TAPS=4 → one of every three offered samples accepted; the following output has error[1]=1 and ready low during MAC/OUT.
- ast_sink_error=2'b01 on one sample → that output has error=2'b01 and the next clean sample → 2'b00. reset_n low mid-MAC → no valid, all outputs 0, coefficients 0.
- Write bank_l tap3=7 during MAC cycle idx=1 → new value used. Same write at idx=3 → old value used.

Source files
------------

// File: rtl/multibank_serial_fir.sv
// multibank_serial_fir: BANKS-bank TAPS-tap FIR sharing one serial MAC, with
// sink backpressure, overrun flagging and optional offset-binary input.
module multibank_serial_fir #(
   parameter int DATA_W       = 12,
   parameter int COEF_W       = 16,
   parameter int TAPS         = 16,
   parameter int BANKS        = 4,
   parameter int BANK_W       = 2,
   parameter int ACC_W        = 32,
   parameter int INPUT_SIGNED = 0
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [BANK_W-1:0]         bank_select,
   input  logic [DATA_W-1:0]         ast_sink_data,
   input  logic                      ast_sink_valid,
   input  logic [1:0]                ast_sink_error,
   output logic                      ast_sink_ready,
   input  logic                      coef_wr_en,
   input  logic [BANK_W-1:0]         coef_wr_bank,
   input  logic [$clog2(TAPS)-1:0]   coef_wr_addr,
   input  logic [COEF_W-1:0]         coef_wr_data,
   output logic [ACC_W-1:0]          ast_source_data,
   output logic                      ast_source_valid,
   output logic [1:0]                ast_source_error,
   output logic                      busy
);
   localparam int AW = $clog2(TAPS);
   localparam int PW = DATA_W + COEF_W;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                   state_q;
   logic signed [DATA_W-1:0] x_q [TAPS];
   logic signed [COEF_W-1:0] coef_q [BANKS][TAPS];
   logic [ACC_W-1:0]         acc_q, acc_d, data_q;
   logic [AW-1:0]            idx_q;
   logic [BANK_W-1:0]        bank_q;
   logic [1:0]               err_q, error_q;
   logic                     ovr_q, valid_q, drop;
   logic signed [DATA_W-1:0] conv;
   logic signed [PW-1:0]     prod;

   assign ast_sink_ready   = state_q == IDLE;
   assign busy             = state_q != IDLE;
   assign drop             = ast_sink_valid && state_q != IDLE;
   assign conv             = INPUT_SIGNED != 0 ? ast_sink_data
                           : {~ast_sink_data[DATA_W-1], ast_sink_data[DATA_W-2:0]};
   assign prod             = PW'(x_q[idx_q]) * PW'(coef_q[bank_q][idx_q]);
   assign acc_d            = acc_q + ACC_W'(prod);
   assign ast_source_data  = data_q;
   assign ast_source_valid = valid_q;
   assign ast_source_error = error_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
         for (int b = 0; b < BANKS; b++)
            for (int k = 0; k < TAPS; k++) coef_q[b][k] <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         bank_q  <= '0;
         err_q   <= '0;
         ovr_q   <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         error_q <= '0;
      end else begin
         // Writes land at the edge, so a tap read in the same cycle still sees the old value.
         if (coef_wr_en && 32'(coef_wr_bank) < BANKS && 32'(coef_wr_addr) < TAPS)
            coef_q[coef_wr_bank][coef_wr_addr] <= coef_wr_data;
         valid_q <= 1'b0;
         if (drop) ovr_q <= 1'b1;
         case (state_q)
            IDLE: if (ast_sink_valid) begin
               x_q[0] <= conv;
               for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
               bank_q  <= bank_select;
               err_q   <= ast_sink_error;
               acc_q   <= '0;
               idx_q   <= '0;
               state_q <= MAC;
            end
            MAC: begin
               acc_q <= acc_d;
               idx_q <= idx_q + AW'(1);
               // Result is registered on the last tap so the strobe lands in OUT; a drop
               // in OUT itself sets ovr afterwards and rides on the following result.
               if (idx_q == AW'(TAPS - 1)) begin
                  data_q  <= acc_d;
                  valid_q <= 1'b1;
                  error_q <= err_q | {ovr_q | drop, 1'b0};
                  ovr_q   <= 1'b0;
                  state_q <= OUT;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_multibank_serial_fir.sv
// tb_multibank_serial_fir: directed + random checks of multibank_serial_fir against
// a sum-of-products reference over a sample history queue.
module tb_multibank_serial_fir;
   localparam int DATA_W = 12;
   localparam int COEF_W = 16;
   localparam int TAPS   = 4;
   localparam int BANKS  = 3;
   localparam int BANK_W = 2;
   localparam int ACC_W  = 30;
   localparam int LAT    = TAPS + 1;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [BANK_W-1:0] bank_select = '0;
   logic [DATA_W-1:0] ast_sink_data = '0;
   logic              ast_sink_valid = 1'b0;
   logic [1:0]        ast_sink_error = '0;
   logic              ast_sink_ready;
   logic              coef_wr_en = 1'b0;
   logic [BANK_W-1:0] coef_wr_bank = '0;
   logic [1:0]        coef_wr_addr = '0;
   logic [COEF_W-1:0] coef_wr_data = '0;
   logic [ACC_W-1:0]  ast_source_data;
   logic              ast_source_valid;
   logic [1:0]        ast_source_error;
   logic              busy;

   int n_chk = 0;
   int n_fail = 0;
   int hist[$];
   int coef_m[4][TAPS];
   logic ovr_m;

   multibank_serial_fir #(
      .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .BANKS(BANKS),
      .BANK_W(BANK_W), .ACC_W(ACC_W), .INPUT_SIGNED(0)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bank_select(bank_select),
      .ast_sink_data(ast_sink_data), .ast_sink_valid(ast_sink_valid),
      .ast_sink_error(ast_sink_error), .ast_sink_ready(ast_sink_ready),
      .coef_wr_en(coef_wr_en), .coef_wr_bank(coef_wr_bank),
      .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
      .ast_source_data(ast_source_data), .ast_source_valid(ast_source_valid),
      .ast_source_error(ast_source_error), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int conv(input logic [DATA_W-1:0] d);
      return int'(d) - (1 << (DATA_W - 1));
   endfunction

   function automatic logic [ACC_W-1:0] fir(input int b);
      longint s = 0;
      for (int k = 0; k < TAPS; k++) s += longint'(hist[k]) * longint'(coef_m[b][k]);
      return ACC_W'(s);
   endfunction

   task automatic model_clear();
      hist = '{0, 0, 0, 0};
      for (int b = 0; b < 4; b++) for (int k = 0; k < TAPS; k++) coef_m[b][k] = 0;
      ovr_m = 1'b0;
   endtask

   task automatic wr(input int b, input int a, input int v);
      coef_wr_en = 1'b1;
      coef_wr_bank = BANK_W'(b);
      coef_wr_addr = 2'(a);
      coef_wr_data = COEF_W'(v);
      tick();
      coef_wr_en = 1'b0;
      if (b < BANKS) coef_m[b][a] = v;
   endtask

   // Offer one sample from IDLE, optionally change bank_select or write a coefficient
   // of the latched bank during MAC tap wr_cycle, then check the single result.
   task automatic run_sample(input logic [DATA_W-1:0] d, input int b, input int b_after,
                             input logic [1:0] e, input int wr_cycle, input int wa, input int wv);
      logic [ACC_W-1:0] exp_v;
      logic [1:0]       exp_e;
      int lat;
      chk("ready_idle", ast_sink_ready, 1'b1);
      ast_sink_data = d;
      ast_sink_valid = 1'b1;
      bank_select = BANK_W'(b);
      ast_sink_error = e;
      hist.push_front(conv(d));
      hist.delete(TAPS);
      if (wr_cycle >= 0 && wa > wr_cycle) coef_m[b][wa] = wv;
      exp_v = fir(b);
      exp_e = e | {ovr_m, 1'b0};
      ovr_m = 1'b0;
      if (wr_cycle >= 0) coef_m[b][wa] = wv;
      coef_wr_bank = BANK_W'(b);
      coef_wr_addr = 2'(wa);
      coef_wr_data = COEF_W'(wv);
      tick();
      ast_sink_valid = 1'b0;
      ast_sink_error = '0;
      bank_select = BANK_W'(b_after);
      lat = 1;
      while (!ast_source_valid && lat < 20) begin
         if (lat == 2) chk("ready_mac", ast_sink_ready, 1'b0);
         coef_wr_en = (lat == wr_cycle + 1);
         tick();
         lat++;
      end
      coef_wr_en = 1'b0;
      chk("latency", 64'(lat), 64'(LAT));
      chk("data", ast_source_data, exp_v);
      chk("error", ast_source_error, exp_e);
      chk("busy_out", busy, 1'b1);
      tick();
      chk("valid_one_cycle", ast_source_valid, 1'b0);
   endtask

   // Cycle-driven stream with offers faster than the block can take them.
   task automatic overrun_stream();
      int free_at = 0;
      int out_at = -1;
      logic [ACC_W-1:0] pend_v = '0;
      logic offer;
      for (int c = 0; c < 32; c++) begin
         if (c == out_at) begin
            chk("ovr_valid", ast_source_valid, 1'b1);
            chk("ovr_data", ast_source_data, pend_v);
            chk("ovr_error", ast_source_error, {ovr_m, 1'b0});
            ovr_m = 1'b0;
         end else chk("ovr_novalid", ast_source_valid, 1'b0);
         chk("ovr_ready", ast_sink_ready, c >= free_at);
         offer = (c < 13 && c % 2 == 0) || c == 11 || c == 18;
         ast_sink_valid = offer;
         ast_sink_data = DATA_W'($urandom);
         bank_select = '0;
         if (offer) begin
            if (c >= free_at) begin
               hist.push_front(conv(ast_sink_data));
               hist.delete(TAPS);
               pend_v = fir(0);
               out_at = c + LAT;
               free_at = c + TAPS + 2;
            end else ovr_m = 1'b1;
         end
         tick();
      end
      ast_sink_valid = 1'b0;
   endtask

   initial begin
      model_clear();
      tick();
      tick();
      chk("rst_ready", ast_sink_ready, 1'b1);
      chk("rst_valid", ast_source_valid, 1'b0);
      chk("rst_data", ast_source_data, '0);
      chk("rst_error", ast_source_error, '0);
      chk("rst_busy", busy, 1'b0);
      reset_n = 1'b1;
      tick();
      // impulse response through bank 0
      wr(0, 0, 1); wr(0, 1, 2); wr(0, 2, 3); wr(0, 3, 4);
      run_sample(12'h801, 0, 0, 2'b00, -1, 0, 0);
      run_sample(12'h800, 0, 0, 2'b00, -1, 0, 0);
      run_sample(12'h800, 0, 0, 2'b00, -1, 0, 0);
      run_sample(12'h800, 0, 0, 2'b00, -1, 0, 0);
      // full-scale offset-binary through bank 1
      for (int k = 0; k < TAPS; k++) wr(1, k, 1);
      for (int i = 0; i < 4; i++) run_sample(12'hFFF, 1, 1, 2'b00, -1, 0, 0);
      // bank_select change mid-MAC only applies at next accept
      wr(0, 1, 0); wr(0, 2, 0); wr(0, 3, 0); wr(2, 0, -1);
      run_sample(12'h805, 0, 2, 2'b00, -1, 0, 0);
      run_sample(12'h805, 2, 2, 2'b00, -1, 0, 0);
      // upstream error propagates, then clears
      run_sample(12'h900, 0, 0, 2'b01, -1, 0, 0);
      run_sample(12'h864, 0, 0, 2'b00, -1, 0, 0);
      // coefficient write to the active bank during MAC
      wr(0, 3, 2);
      run_sample(12'h810, 0, 0, 2'b00, 1, 3, 7);
      wr(0, 3, 2);
      run_sample(12'h820, 0, 0, 2'b00, 3, 3, 7);
      // overrun, including a drop in the OUT cycle
      overrun_stream();
      // random coefficients, samples, banks and errors
      for (int b = 0; b < BANKS; b++)
         for (int k = 0; k < TAPS; k++) wr(b, k, $urandom_range(65535, 0) - 32768);
      wr(3, 0, 9);
      for (int i = 0; i < 8; i++)
         run_sample(DATA_W'($urandom), $urandom_range(BANKS - 1, 0), $urandom_range(BANKS - 1, 0),
                    2'($urandom_range(3, 0)), -1, 0, 0);
      // reset during MAC aborts and clears coefficients
      ast_sink_data = 12'hABC;
      ast_sink_valid = 1'b1;
      tick();
      ast_sink_valid = 1'b0;
      tick();
      reset_n = 1'b0;
      #1;
      chk("arst_ready", ast_sink_ready, 1'b1);
      chk("arst_valid", ast_source_valid, 1'b0);
      chk("arst_data", ast_source_data, '0);
      chk("arst_error", ast_source_error, '0);
      chk("arst_busy", busy, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("arst_novalid", ast_source_valid, 1'b0);
      end
      reset_n = 1'b1;
      model_clear();
      tick();
      run_sample(12'h9AB, 0, 0, 2'b00, -1, 0, 0);
      run_sample(12'h123, 2, 2, 2'b00, -1, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
